// File: rtl/cam_cfg_ctrl.sv
// Sensor register configuration sequencer: walks a register ROM and writes each
// entry over SCCB. Each write is retried on NACK or timeout, then a settle delay follows.
module cam_cfg_ctrl #(
  parameter logic [7:0]  REG_NUM   = 8'd200,
  parameter logic [15:0] DLY_WR    = 16'd2400,
  parameter logic [15:0] DLY_RST   = 16'd24000,
  parameter logic [15:0] TIMEOUT   = 16'd48000,
  parameter logic [1:0]  MAX_RETRY = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        initial_en,
  output logic [7:0]  lut_addr,
  input  logic [15:0] lut_data,
  output logic        sccb_req,
  output logic [7:0]  sccb_addr,
  output logic [7:0]  sccb_wdata,
  input  logic        sccb_busy,
  input  logic        sccb_done,
  input  logic        sccb_nack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [7:0]  cfg_idx
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DELAY, DONE, ERR} state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] wdata;
  } sccb_cmd_t;

  state_t    state, state_d;
  sccb_cmd_t cmd_q;
  logic      en_q, armed;
  logic [15:0] tmo_cnt, dly_cnt;
  logic [1:0]  retry;
  logic rise, last_idx;
  logic start, issue, load_dly, advance, retry_inc;

  // armed keeps an initial_en that is already high when reset releases from
  // counting as a rising edge: it must be seen low at least once first.
  assign rise     = initial_en & ~en_q & armed;
  assign last_idx = (cfg_idx == REG_NUM - 8'd1);

  assign sccb_addr  = cmd_q.addr;
  assign sccb_wdata = cmd_q.wdata;
  assign cfg_busy   = (state == FETCH) || (state == ISSUE) ||
                      (state == WAIT)  || (state == DELAY);
  assign cfg_done   = (state == DONE);
  assign cfg_err    = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    start     = 1'b0;
    issue     = 1'b0;
    load_dly  = 1'b0;
    advance   = 1'b0;
    retry_inc = 1'b0;
    if (state != IDLE && !initial_en) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:  if (rise) begin start = 1'b1; state_d = FETCH; end
        FETCH: state_d = ISSUE;
        ISSUE: begin
          if (lut_data == 16'hFFFF) state_d = DONE;
          else if (!sccb_busy) begin
            issue   = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (sccb_done && !sccb_nack) begin
            load_dly = 1'b1;
            state_d  = DELAY;
          end else if (sccb_done || tmo_cnt == TIMEOUT) begin
            if (retry < MAX_RETRY) begin
              retry_inc = 1'b1;
              state_d   = ISSUE;
            end else begin
              state_d = ERR;
            end
          end
        end
        DELAY: begin
          if (dly_cnt == 16'd0) begin
            if (last_idx) state_d = DONE;
            else begin
              advance = 1'b1;
              state_d = FETCH;
            end
          end
        end
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      armed    <= 1'b0;
      sccb_req <= 1'b0;
      cmd_q    <= '0;
      cfg_idx  <= 8'd0;
      lut_addr <= 8'd0;
      retry    <= 2'd0;
      tmo_cnt  <= 16'd0;
      dly_cnt  <= 16'd0;
    end else begin
      en_q     <= initial_en;
      sccb_req <= issue;
      if (!initial_en) armed <= 1'b1;

      if (start) begin
        cfg_idx  <= 8'd0;
        lut_addr <= 8'd0;
        retry    <= 2'd0;
      end else if (advance) begin
        cfg_idx  <= cfg_idx + 8'd1;
        lut_addr <= lut_addr + 8'd1;
        retry    <= 2'd0;
      end else if (retry_inc) begin
        retry <= retry + 2'd1;
      end

      // Timeout counter saturates at TIMEOUT so it never wraps while waiting.
      if (issue) begin
        cmd_q   <= lut_data;
        tmo_cnt <= 16'd0;
      end else if (state == WAIT && tmo_cnt != TIMEOUT) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end

      // Entry 0 is the sensor soft reset and needs the long settle time.
      if (load_dly)
        dly_cnt <= (cfg_idx == 8'd0) ? DLY_RST : DLY_WR;
      else if (state == DELAY && dly_cnt != 16'd0)
        dly_cnt <= dly_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_cam_cfg_ctrl.sv
// Bench for cam_cfg_ctrl: ROM and SCCB slave models, scenario tasks checking
// request streams, outcomes and settle timing against a table-walk reference.
module tb_cam_cfg_ctrl;
  localparam logic [7:0]  REG_NUM   = 8'd3;
  localparam logic [15:0] DLY_WR    = 16'd20;
  localparam logic [15:0] DLY_RST   = 16'd50;
  localparam logic [15:0] TIMEOUT   = 16'd30;
  localparam logic [1:0]  MAX_RETRY = 2'd3;

  logic        clk = 1'b0, rst = 1'b1, initial_en = 1'b0;
  logic [7:0]  lut_addr, sccb_addr, sccb_wdata, cfg_idx;
  logic [15:0] lut_data;
  logic        sccb_req, sccb_busy = 1'b0, sccb_done = 1'b0, sccb_nack = 1'b0;
  logic        cfg_busy, cfg_done, cfg_err;

  cam_cfg_ctrl #(.REG_NUM(REG_NUM), .DLY_WR(DLY_WR), .DLY_RST(DLY_RST),
                 .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .initial_en(initial_en), .lut_addr(lut_addr),
    .lut_data(lut_data), .sccb_req(sccb_req), .sccb_addr(sccb_addr),
    .sccb_wdata(sccb_wdata), .sccb_busy(sccb_busy), .sccb_done(sccb_done),
    .sccb_nack(sccb_nack), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .cfg_idx(cfg_idx));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register ROM with one cycle of read latency.
  logic [15:0] rom [0:255];
  always @(posedge clk) lut_data <= rom[lut_addr];

  typedef struct { logic [7:0] a; logic [7:0] d; int c; } req_t;
  req_t reqs[$];
  int   ack_dones[$];
  int   nack_left [256];   // 255 = NACK forever
  bit   no_resp = 1'b0;
  int   done_at;

  // SCCB slave: logs each request, answers after a random latency.
  int         s_lat;
  bit         s_nk;
  logic [7:0] s_a;
  always @(negedge clk) begin
    if (sccb_req) begin
      reqs.push_back('{sccb_addr, sccb_wdata, cyc});
      if (!no_resp) begin
        s_a = sccb_addr;
        s_lat = $urandom_range(1, 6);
        sccb_busy = 1'b1;
        repeat (s_lat) @(negedge clk);
        s_nk = 1'b0;
        if (nack_left[s_a] == 255) s_nk = 1'b1;
        else if (nack_left[s_a] > 0) begin
          s_nk = 1'b1;
          nack_left[s_a] = nack_left[s_a] - 1;
        end
        sccb_done = 1'b1;
        sccb_nack = s_nk;
        if (!s_nk) ack_dones.push_back(cyc + 1);
        @(negedge clk);
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        sccb_busy = 1'b0;
      end
    end
  end

  task automatic clear_plan();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'h0000;
      nack_left[i] = 0;
    end
    no_resp = 1'b0;
  endtask

  // Walks the table the way the sequence is described: each entry gets up to
  // 1+MAX_RETRY attempts, an end marker stops early, a fully failed entry aborts.
  task automatic test_table(input string name, input int budget);
    logic [15:0] exp[$];
    bit          e_err = 1'b0, ok;
    logic [7:0]  e_idx = REG_NUM - 8'd1;
    int          nl[256];
    int          n = 0;
    logic [7:0]  a;
    nl = nack_left;
    begin : model
      for (int i = 0; i < int'(REG_NUM); i++) begin
        if (rom[i] == 16'hFFFF) begin e_idx = 8'(i); disable model; end
        ok = 1'b0;
        for (int t = 0; t <= int'(MAX_RETRY); t++) begin
          exp.push_back(rom[i]);
          a = rom[i][15:8];
          if (no_resp || nl[a] == 255) ok = 1'b0;
          else if (nl[a] > 0) begin nl[a] = nl[a] - 1; ok = 1'b0; end
          else ok = 1'b1;
          if (ok) break;
        end
        if (!ok) begin e_err = 1'b1; e_idx = 8'(i); disable model; end
      end
    end
    reqs.delete();
    ack_dones.delete();
    done_at = -1;
    initial_en = 1'b0;
    repeat (3) @(negedge clk);
    initial_en = 1'b1;
    while (!(cfg_done || cfg_err) && n < budget) begin
      @(negedge clk);
      n++;
      if (cfg_done && done_at < 0) done_at = cyc;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: no cfg_done/cfg_err within %0d cycles", name, budget);
    end
    repeat (int'(TIMEOUT) + 30) @(negedge clk);
    checks++;
    if (reqs.size() != exp.size()) begin
      failures++;
      $display("FAIL %s req_count: got %0d expected %0d", name, reqs.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < reqs.size(); i++) begin
      checks++;
      if ({reqs[i].a, reqs[i].d} !== exp[i]) begin
        failures++;
        $display("FAIL %s req[%0d]: got %h%h expected %h", name, i, reqs[i].a, reqs[i].d, exp[i]);
      end
    end
    checks++;
    if ({cfg_busy, cfg_done, cfg_err} !== {1'b0, ~e_err, e_err}) begin
      failures++;
      $display("FAIL %s flags busy/done/err: got %b expected %b", name,
               {cfg_busy, cfg_done, cfg_err}, {1'b0, ~e_err, e_err});
    end
    checks++;
    if (cfg_idx !== e_idx) begin
      failures++;
      $display("FAIL %s cfg_idx: got %0d expected %0d", name, cfg_idx, e_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    initial_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lut_addr, cfg_idx, sccb_req, sccb_addr, sccb_wdata, cfg_busy, cfg_done, cfg_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h %h %b %h %h %b%b%b expected all zero",
               lut_addr, cfg_idx, sccb_req, sccb_addr, sccb_wdata, cfg_busy, cfg_done, cfg_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_basic();
    clear_plan();
    rom[0] = 16'h1280; rom[1] = 16'h1111; rom[2] = 16'h2222;
  endtask

  // Settle of N: N+1 DELAY cycles counting down, FETCH, then ISSUE registers sccb_req.
  task automatic test_basic();
    load_basic();
    test_table("basic", 2000);
    checks++;
    if (ack_dones.size() == 3 && reqs.size() == 3) begin
      if (reqs[1].c - ack_dones[0] != int'(DLY_RST) + 3) begin
        failures++;
        $display("FAIL basic gap_rst: got %0d expected %0d", reqs[1].c - ack_dones[0], int'(DLY_RST) + 3);
      end
      checks++;
      if (reqs[2].c - ack_dones[1] != int'(DLY_WR) + 3) begin
        failures++;
        $display("FAIL basic gap_wr: got %0d expected %0d", reqs[2].c - ack_dones[1], int'(DLY_WR) + 3);
      end
      checks++;
      if (done_at - ack_dones[2] != int'(DLY_WR) + 1) begin
        failures++;
        $display("FAIL basic done_time: got %0d expected %0d", done_at - ack_dones[2], int'(DLY_WR) + 1);
      end
    end else begin
      failures++;
      $display("FAIL basic handshakes: got %0d acks expected 3", ack_dones.size());
    end
  endtask

  task automatic test_nack_retry();
    load_basic();
    nack_left[8'h11] = 2;
    test_table("nack_twice", 2000);
  endtask

  task automatic test_always_nack();
    load_basic();
    nack_left[8'h11] = 255;
    test_table("nack_always", 2000);
  endtask

  // Timeout fires after TIMEOUT counted WAIT cycles plus one to detect, then ISSUE.
  task automatic test_timeout();
    load_basic();
    no_resp = 1'b1;
    test_table("timeout", 2000);
    checks++;
    if (reqs.size() < 2 || reqs[1].c - reqs[0].c != int'(TIMEOUT) + 2) begin
      failures++;
      $display("FAIL timeout_gap: got %0d expected %0d",
               reqs.size() < 2 ? -1 : reqs[1].c - reqs[0].c, int'(TIMEOUT) + 2);
    end
    no_resp = 1'b0;
  endtask

  // End marker is seen in ISSUE, two cycles after the entry 0 delay expires.
  task automatic test_end_marker();
    load_basic();
    rom[1] = 16'hFFFF;
    test_table("end_marker", 2000);
    checks++;
    if (ack_dones.size() != 1 || done_at - ack_dones[0] != int'(DLY_RST) + 3) begin
      failures++;
      $display("FAIL end_marker_time: got %0d expected %0d",
               ack_dones.size() != 1 ? -1 : done_at - ack_dones[0], int'(DLY_RST) + 3);
    end
  endtask

  task automatic test_drop();
    int n = 0;
    load_basic();
    reqs.delete();
    ack_dones.delete();
    initial_en = 1'b0;
    repeat (3) @(negedge clk);
    initial_en = 1'b1;
    while (ack_dones.size() < 2 && n < 2000) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    initial_en = 1'b0;
    @(negedge clk);
    checks++;
    if (n >= 2000 || {cfg_busy, cfg_done, cfg_err} !== 3'b000) begin
      failures++;
      $display("FAIL drop_flags: got %b expected 000 (wait %0d)", {cfg_busy, cfg_done, cfg_err}, n);
    end
    reqs.delete();
    repeat (2) @(negedge clk);
    initial_en = 1'b1;
    n = 0;
    while (reqs.size() < 1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (reqs.size() < 1 || {reqs[0].a, reqs[0].d} !== 16'h1280 || lut_addr !== 8'd0) begin
      failures++;
      $display("FAIL drop_restart: got req %0d lut_addr %0d expected entry 0 (1280) lut_addr 0",
               reqs.size(), lut_addr);
    end
    n = 0;
    while (!cfg_done && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (!cfg_done) begin
      failures++;
      $display("FAIL drop_complete: cfg_done got 0 expected 1");
    end
  endtask

  task automatic test_rst_mid();
    int n = 0;
    load_basic();
    reqs.delete();
    ack_dones.delete();
    initial_en = 1'b0;
    repeat (3) @(negedge clk);
    initial_en = 1'b1;
    while (ack_dones.size() < 1 && n < 2000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({lut_addr, cfg_idx, sccb_req, sccb_addr, sccb_wdata, cfg_busy, cfg_done, cfg_err} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got addr %h wdata %h busy %b expected all zero",
               sccb_addr, sccb_wdata, cfg_busy);
    end
    rst = 1'b0;
    reqs.delete();
    repeat (100) @(negedge clk);
    checks++;
    if (reqs.size() != 0 || cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_restart: got %0d reqs busy %b expected 0 reqs busy 0", reqs.size(), cfg_busy);
    end
    test_table("after_rst", 2000);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_plan();
      for (int i = 0; i < int'(REG_NUM); i++) begin
        rom[i] = 16'($urandom_range(0, 16'hFFFE));
        if ($urandom_range(0, 5) == 0) rom[i] = 16'hFFFF;
        else nack_left[rom[i][15:8]] = $urandom_range(0, 4);
      end
      test_table($sformatf("random%0d", it), 3000);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin rom[i] = 16'h0; nack_left[i] = 0; end
    test_reset();
    test_basic();
    test_nack_retry();
    test_always_nack();
    test_timeout();
    test_end_marker();
    test_drop();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
